// File: rtl/tpu_tile_scheduler_pkg.sv
// Shared types for the systolic-array tile scheduler.
//   TILE       : array edge length (4 is the only supported value)
//   IDXW       : buffer index width
//   state_t    : scheduler FSM states
//   tile_cmd_t : one tile command (buffer bases, valid rows, reduction depth)
package tpu_pkg;

  localparam int TILE = 4;
  localparam int IDXW = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_NEXT,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic [15:0] a_base;
    logic [15:0] b_base;
    logic [15:0] c_base;
    logic [2:0]  rows;
    logic [7:0]  k;
  } tile_cmd_t;

endpackage

// File: rtl/tpu_tile_scheduler_if.sv
// Tile command channel between the scheduler and the systolic-array core.
//   master : scheduler side. It drives cmd_valid and the payload, and receives
//            cmd_ready and tile_done.
//   slave  : array side.
interface tpu_tile_scheduler_if;

  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_a_base;
  logic [15:0] cmd_b_base;
  logic [15:0] cmd_c_base;
  logic [2:0]  cmd_rows;
  logic [7:0]  cmd_k;
  logic        tile_done;

  modport master (
    output cmd_valid, cmd_a_base, cmd_b_base, cmd_c_base, cmd_rows, cmd_k,
    input  cmd_ready, tile_done
  );

  modport slave (
    input  cmd_valid, cmd_a_base, cmd_b_base, cmd_c_base, cmd_rows, cmd_k,
    output cmd_ready, tile_done
  );

endinterface

// File: rtl/tpu_tile_scheduler_addr_gen.sv
// tpu_tile_addr_gen: holds the mt (inner) and nt (outer) tile counters. It
// computes the command fields of the tile that the counters will address
// after this edge.
//   clk, rst_n : clock and asynchronous active-low reset
//   clr        : zero both counters (job start)
//   adv        : step to the next tile (mt inner, nt outer)
//   k, m, n    : problem size (the caller supplies the live inputs on the start cycle)
//   cmd_nxt    : fields for the tile at the post-edge counter values
//   last       : the current counters address the final tile
module tpu_tile_addr_gen #(
  parameter int TILE = 4,
  parameter int IDXW = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               adv,
  input  logic [7:0]         k,
  input  logic [7:0]         m,
  input  logic [7:0]         n,
  output tpu_pkg::tile_cmd_t cmd_nxt,
  output logic               last
);

  logic [6:0] mt, nt, mt_nxt, nt_nxt, mt_last, nt_last;
  logic [8:0] m_up, n_up;

  // ceil(x/TILE) - 1. A zero dimension never reaches the issue path, so the
  // wrap to all-ones in that case does not matter.
  assign m_up    = {1'b0, m} + 9'(TILE - 1);
  assign n_up    = {1'b0, n} + 9'(TILE - 1);
  assign mt_last = 7'(m_up / 9'(TILE)) - 7'd1;
  assign nt_last = 7'(n_up / 9'(TILE)) - 7'd1;

  assign last = (mt == mt_last) && (nt == nt_last);

  always_comb begin
    mt_nxt = mt;
    nt_nxt = nt;
    if (clr) begin
      mt_nxt = '0;
      nt_nxt = '0;
    end else if (adv) begin
      if (mt == mt_last) begin
        mt_nxt = '0;
        nt_nxt = nt + 7'd1;
      end else begin
        mt_nxt = mt + 7'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mt <= '0;
      nt <= '0;
    end else begin
      mt <= mt_nxt;
      nt <= nt_nxt;
    end
  end

  // The fields are computed from the post-edge counters. The scheduler can
  // then register them on the same edge that enters ISSUE.
  always_comb begin
    cmd_nxt.a_base = IDXW'(mt_nxt) * IDXW'(k);
    cmd_nxt.b_base = IDXW'(nt_nxt) * IDXW'(k);
    cmd_nxt.c_base = IDXW'(nt_nxt) * IDXW'(m) + IDXW'(mt_nxt) * IDXW'(TILE);
    cmd_nxt.rows   = ((mt_nxt == mt_last) && (m[1:0] != 2'b00)) ? {1'b0, m[1:0]} : 3'(TILE);
    cmd_nxt.k      = k;
  end

endmodule

// File: rtl/tpu_tile_scheduler.sv
// tpu_tile_scheduler: walks a K x M x N matmul as 4x4 output tiles. It issues
// one command per tile and waits for tile_done before issuing the next.
//   clk, rst_n        : clock and asynchronous active-low reset
//   in_valid, K, M, N : job start pulse and problem size (sampled in IDLE only)
//   busy, done        : job in progress / one-cycle completion pulse
//   cmd               : tile command channel (master side)
//   perf_cycles, perf_stall : present only when TPU_SCHED_PERF_EN is defined
//
// state | meaning
// IDLE  | waiting for in_valid
// ISSUE | cmd_valid high, waiting for cmd_ready
// WAIT  | command accepted, waiting for tile_done
// NEXT  | step to the next tile, or finish
// DONE  | done pulse, then back to IDLE
module tpu_tile_scheduler #(
  parameter int TILE = tpu_pkg::TILE,
  parameter int IDXW = tpu_pkg::IDXW
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] K,
  input  logic [7:0] M,
  input  logic [7:0] N,
  output logic       busy,
  output logic       done,
`ifdef TPU_SCHED_PERF_EN
  output logic [31:0] perf_cycles,
  output logic [31:0] perf_stall,
`endif
  tpu_tile_scheduler_if.master cmd
);
  import tpu_pkg::*;

  state_t    state, state_nxt;
  logic [7:0] k_q, m_q, n_q, k_eff, m_eff, n_eff;
  logic      start, adv, last, cmd_valid_q;
  tile_cmd_t cmd_nxt, cmd_q;

  assign start = (state == ST_IDLE) && in_valid;
  assign k_eff = start ? K : k_q;
  assign m_eff = start ? M : m_q;
  assign n_eff = start ? N : n_q;

  tpu_tile_addr_gen #(.TILE(TILE), .IDXW(IDXW)) u_addr_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (start),
    .adv     (adv),
    .k       (k_eff),
    .m       (m_eff),
    .n       (n_eff),
    .cmd_nxt (cmd_nxt),
    .last    (last)
  );

  always_comb begin
    state_nxt = state;
    adv       = 1'b0;
    case (state)
      ST_IDLE:  if (in_valid) state_nxt = (K == 8'd0 || M == 8'd0 || N == 8'd0) ? ST_DONE : ST_ISSUE;
      ST_ISSUE: if (cmd_valid_q && cmd.cmd_ready) state_nxt = ST_WAIT;
      ST_WAIT:  if (cmd.tile_done) state_nxt = ST_NEXT;
      ST_NEXT: begin
        if (last) begin
          state_nxt = ST_DONE;
        end else begin
          adv       = 1'b1;
          state_nxt = ST_ISSUE;
        end
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // The outputs are registered from the next state, so they line up with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_q       <= '0;
      k_q         <= '0;
      m_q         <= '0;
      n_q         <= '0;
    end else begin
      state       <= state_nxt;
      busy        <= (state_nxt != ST_IDLE);
      done        <= (state_nxt == ST_DONE);
      cmd_valid_q <= (state_nxt == ST_ISSUE);
      if (start) begin
        k_q <= K;
        m_q <= M;
        n_q <= N;
      end
      // The payload loads only on entry to ISSUE, so it holds steady under backpressure.
      if (state_nxt == ST_ISSUE && state != ST_ISSUE) cmd_q <= cmd_nxt;
    end
  end

  assign cmd.cmd_valid  = cmd_valid_q;
  assign cmd.cmd_a_base = cmd_q.a_base;
  assign cmd.cmd_b_base = cmd_q.b_base;
  assign cmd.cmd_c_base = cmd_q.c_base;
  assign cmd.cmd_rows   = cmd_q.rows;
  assign cmd.cmd_k      = cmd_q.k;

`ifdef TPU_SCHED_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cycles <= '0;
      perf_stall  <= '0;
    end else if (start) begin
      perf_cycles <= '0;
      perf_stall  <= '0;
    end else begin
      if (busy) perf_cycles <= perf_cycles + 32'd1;
      if (cmd_valid_q && !cmd.cmd_ready) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tpu_tile_scheduler.sv
// Directed bench for tpu_tile_scheduler. Inputs are driven on the falling
// edge, and outputs are sampled on the falling edge that follows.
module tb_tpu_tile_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] K, M, N;
  logic       busy, done;
`ifdef TPU_SCHED_PERF_EN
  logic [31:0] perf_cycles, perf_stall;
`endif

  int total = 0;
  int bad   = 0;

  tpu_tile_scheduler_if cmd_if ();

  tpu_tile_scheduler dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .K           (K),
    .M           (M),
    .N           (N),
    .busy        (busy),
    .done        (done),
`ifdef TPU_SCHED_PERF_EN
    .perf_cycles (perf_cycles),
    .perf_stall  (perf_stall),
`endif
    .cmd         (cmd_if)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $error("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench did not finish");
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_cmd(input string tag, input int a, input int b, input int c,
                         input int rows, input int k);
    chk({tag, ".valid"}, 32'(cmd_if.cmd_valid), 32'd1);
    chk({tag, ".a"},     32'(cmd_if.cmd_a_base), 32'(a));
    chk({tag, ".b"},     32'(cmd_if.cmd_b_base), 32'(b));
    chk({tag, ".c"},     32'(cmd_if.cmd_c_base), 32'(c));
    chk({tag, ".rows"},  32'(cmd_if.cmd_rows),   32'(rows));
    chk({tag, ".k"},     32'(cmd_if.cmd_k),      32'(k));
  endtask

  task automatic start_job(input int k, input int m, input int n);
    in_valid = 1'b1;
    K = 8'(k);
    M = 8'(m);
    N = 8'(n);
    step();
    in_valid = 1'b0;
  endtask

  // Expected tiles for K=3 M=6 N=5 (nt outer, mt inner).
  int exp_a[4]    = '{0, 3, 0, 3};
  int exp_b[4]    = '{0, 0, 3, 3};
  int exp_c[4]    = '{0, 4, 6, 10};
  int exp_rows[4] = '{4, 2, 4, 2};

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    K = '0; M = '0; N = '0;
    cmd_if.cmd_ready = 1'b0;
    cmd_if.tile_done = 1'b0;
    step(); step();

    // reset values
    chk("rst.busy",  32'(busy), 32'd0);
    chk("rst.done",  32'(done), 32'd0);
    chk("rst.valid", 32'(cmd_if.cmd_valid), 32'd0);
    chk("rst.a",     32'(cmd_if.cmd_a_base), 32'd0);
    chk("rst.rows",  32'(cmd_if.cmd_rows), 32'd0);
    chk("rst.k",     32'(cmd_if.cmd_k), 32'd0);
    rst_n = 1'b1;
    step();

    // single tile: K=M=N=4, tile_done 10 cycles after accept
    start_job(4, 4, 4);
    chk("t1.busy", 32'(busy), 32'd1);
    chk_cmd("t1", 0, 0, 0, 4, 4);
    cmd_if.cmd_ready = 1'b1;
    step();
    cmd_if.cmd_ready = 1'b0;
    chk("t1.accept_drop", 32'(cmd_if.cmd_valid), 32'd0);
    repeat (9) step();
    chk("t1.no_second_cmd", 32'(cmd_if.cmd_valid), 32'd0);
    cmd_if.tile_done = 1'b1;
    step();
    cmd_if.tile_done = 1'b0;
    chk("t1.next_done", 32'(done), 32'd0);
    step();
    chk("t1.done", 32'(done), 32'd1);
    chk("t1.done_busy", 32'(busy), 32'd1);
    step();
    chk("t1.done_clear", 32'(done), 32'd0);
    chk("t1.idle_busy", 32'(busy), 32'd0);

    // partial tiles: K=3 M=6 N=5
    start_job(3, 6, 5);
    for (int i = 0; i < 4; i++) begin
      chk_cmd($sformatf("t2.tile%0d", i), exp_a[i], exp_b[i], exp_c[i], exp_rows[i], 3);
      cmd_if.cmd_ready = 1'b1;
      step();
      cmd_if.cmd_ready = 1'b0;
      chk($sformatf("t2.wait%0d", i), 32'(cmd_if.cmd_valid), 32'd0);
      cmd_if.tile_done = 1'b1;
      step();
      cmd_if.tile_done = 1'b0;
      chk($sformatf("t2.next%0d", i), 32'(cmd_if.cmd_valid), 32'd0);
      step();
    end
    chk("t2.done", 32'(done), 32'd1);
    step();
    chk("t2.idle", 32'(busy), 32'd0);

    // zero dimension
    start_job(5, 0, 3);
    chk("t3.done", 32'(done), 32'd1);
    chk("t3.busy", 32'(busy), 32'd1);
    chk("t3.valid", 32'(cmd_if.cmd_valid), 32'd0);
    step();
    chk("t3.done_clear", 32'(done), 32'd0);
    chk("t3.busy_clear", 32'(busy), 32'd0);
    chk("t3.valid2", 32'(cmd_if.cmd_valid), 32'd0);
`ifdef TPU_SCHED_PERF_EN
    chk("t3.perf_cycles", perf_cycles, 32'd1);
`endif

    // backpressure plus spurious inputs: K=2 M=8 N=4 (two tiles)
    start_job(2, 8, 4);
    for (int c = 1; c <= 5; c++) begin
      chk_cmd($sformatf("t4.stall%0d", c), 0, 0, 0, 4, 2);
      if (c == 2) begin
        cmd_if.tile_done = 1'b1;
        in_valid = 1'b1;
        K = 8'd9; M = 8'd1; N = 8'd1;
      end
      step();
      cmd_if.tile_done = 1'b0;
      in_valid = 1'b0;
    end
    chk_cmd("t4.post_stall", 0, 0, 0, 4, 2);
    cmd_if.cmd_ready = 1'b1;
    step();
    chk("t4.accept_drop", 32'(cmd_if.cmd_valid), 32'd0);
    in_valid = 1'b1;
    K = 8'd9; M = 8'd1; N = 8'd1;
    step();
    in_valid = 1'b0;
    chk("t4.wait_busy", 32'(busy), 32'd1);
    chk("t4.wait_valid", 32'(cmd_if.cmd_valid), 32'd0);
    cmd_if.tile_done = 1'b1;
    step();
    cmd_if.tile_done = 1'b0;
    step();
    chk_cmd("t4.tile1", 2, 0, 4, 4, 2);
    step();
    cmd_if.cmd_ready = 1'b0;
    cmd_if.tile_done = 1'b1;
    step();
    cmd_if.tile_done = 1'b0;
    step();
    chk("t4.done", 32'(done), 32'd1);
    step();
    chk("t4.idle", 32'(busy), 32'd0);
`ifdef TPU_SCHED_PERF_EN
    chk("t4.perf_stall", perf_stall, 32'd5);
`endif

    // mid-job reset during WAIT of tile 2, then a fresh job
    cmd_if.cmd_ready = 1'b1;
    start_job(3, 6, 5);
    step();
    cmd_if.tile_done = 1'b1;
    step();
    cmd_if.tile_done = 1'b0;
    step();
    chk_cmd("t5.tile1", 3, 0, 4, 2, 3);
    step();
    rst_n = 1'b0;
    #1;
    chk("t5.rst_busy",  32'(busy), 32'd0);
    chk("t5.rst_valid", 32'(cmd_if.cmd_valid), 32'd0);
    chk("t5.rst_a",     32'(cmd_if.cmd_a_base), 32'd0);
    chk("t5.rst_c",     32'(cmd_if.cmd_c_base), 32'd0);
    chk("t5.rst_k",     32'(cmd_if.cmd_k), 32'd0);
    step();
    rst_n = 1'b1;
    cmd_if.cmd_ready = 1'b0;
    step();
    chk("t5.no_reissue", 32'(cmd_if.cmd_valid), 32'd0);
    chk("t5.idle", 32'(busy), 32'd0);
    start_job(1, 4, 8);
    chk_cmd("t5.new0", 0, 0, 0, 4, 1);
    cmd_if.cmd_ready = 1'b1;
    step();
    cmd_if.tile_done = 1'b1;
    step();
    cmd_if.tile_done = 1'b0;
    step();
    chk_cmd("t5.new1", 0, 1, 4, 4, 1);
    step();
    cmd_if.cmd_ready = 1'b0;
    cmd_if.tile_done = 1'b1;
    step();
    cmd_if.tile_done = 1'b0;
    step();
    chk("t5.done", 32'(done), 32'd1);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tpu_tile_scheduler.md
# tpu_tile_scheduler

Sequencing controller that sits above the 4×4 systolic-array core and walks a K×M×N matrix multiply as a series of 4×4 output tiles. It latches the problem size on `in_valid` and issues one tile command per output tile, carrying the A/B/C buffer base indices, the valid row count and the reduction depth. It waits for the array's completion before issuing the next command, and holds `busy` for the whole job. This lets the array core stay single-tile and stateless across tiles.

## Interface
Parameters:
- `TILE`, 4 — systolic array edge length; the only supported value is 4.
- `IDXW`, 16 — buffer index width.

Ports:
- `clk` in 1 — clock.
- `rst_n` in 1 — reset, asynchronous, active-low.
- `in_valid` in 1 — job start pulse; K/M/N sampled this cycle.
- `K`, `M`, `N` in 8 each — reduction depth, A rows, B columns.
- `busy` out 1 — job in progress.
- `done` out 1 — one-cycle pulse when the job completes.
- `cmd_valid` out 1 — tile command valid.
- `cmd_ready` in 1 — array accepts the command.
- `cmd_a_base` out 16 — A buffer start index, `mt*K`.
- `cmd_b_base` out 16 — B buffer start index, `nt*K`.
- `cmd_c_base` out 16 — C buffer start index, `nt*M + mt*4`.
- `cmd_rows` out 3 — valid output rows in the tile, 1..4.
- `cmd_k` out 8 — reduction depth, equal to the latched K.
- `tile_done` in 1 — array finished writing the current tile.

## Operation
- Tile counts: `MT = ceil(M/4)` and `NT = ceil(N/4)`, 7 bits each. Counters `mt` (0..MT-1) and `nt` (0..NT-1).
- Order: `mt` is the inner loop and `nt` the outer loop. The sequence is (nt0,mt0), (nt0,mt1), …, (nt1,mt0), and so on.
- `cmd_rows` is `M - 4*mt` when `mt == MT-1` and `M[1:0] != 0`; otherwise it is 4.
- FSM states: IDLE, ISSUE, WAIT, NEXT, DONE.
  - IDLE: `in_valid` latches K/M/N and clears `mt` and `nt`. If any of K/M/N is zero the FSM goes to DONE; otherwise it goes to ISSUE.
  - ISSUE: `cmd_valid` is 1. On `cmd_valid && cmd_ready` the FSM goes to WAIT.
  - WAIT: on `tile_done` the FSM goes to NEXT.
  - NEXT: if `mt` and `nt` are both at their last value, go to DONE. Otherwise increment `mt`; when `mt` wraps, increment `nt`. Then go to ISSUE.
  - DONE: `done` is 1 for this cycle, then the FSM returns to IDLE.
- `busy` is 1 in every state except IDLE. It is registered and tracks the state.
- `in_valid` is ignored outside IDLE; the latched K/M/N stay unchanged.
- `tile_done` is ignored outside WAIT.
- The `cmd_*` payload is registered and stays stable while `cmd_valid && !cmd_ready`.
- Base arithmetic is 16-bit unsigned. The worst case is 63*255 + 252, which cannot overflow.

## Timing
- Reset values: `busy`=0, `done`=0, `cmd_valid`=0, all `cmd_*` fields =0, state IDLE, counters 0.
- Start: `in_valid` at cycle 0 gives `busy`=1 and `cmd_valid`=1 at cycle 1.
- Zero dimension: `done` at cycle 1, `busy`=0 at cycle 2.
- Accept handshake: a handshake at cycle t drops `cmd_valid` at t+1.
- Between tiles: `tile_done` at cycle t puts the FSM in NEXT at t+1 and raises `cmd_valid` for the next tile at t+2.
- Last tile: `tile_done` at cycle t puts the FSM in NEXT at t+1, raises `done` at t+2, and drops `busy` at t+3.
- Reset mid-job returns everything to reset values immediately. No command is re-issued after reset.

## Configuration
- `TPU_SCHED_PERF_EN` defined:
  - Adds output `perf_cycles` (32 bits). It clears when a job starts, counts every cycle while `busy`, and holds after `done`.
  - Adds output `perf_stall` (32 bits), which counts cycles with `cmd_valid && !cmd_ready`.
- `TPU_SCHED_PERF_EN` undefined: neither port nor counter exists, and all other behaviour is identical.

## Structure
- Shared package `tpu_pkg`:
  - FSM state enum.
  - `TILE`.
  - Tile-command struct: `a_base`, `b_base`, `c_base`, `rows`, `k`.
- Sub-module `tpu_tile_addr_gen`:
  - Holds the `mt`/`nt` counters and the base/rows computation.
  - Inputs: `clr`, `adv`, latched K/M/N.
  - Outputs: the command fields and `last`.
- The FSM and handshake logic remain in `tpu_tile_scheduler`.

## Test plan
- **Single tile:** K=4, M=4, N=4; tile_done 10 cycles after accept → exactly one command {a0, b0, c0, rows 4, k 4}; `done` 2 cycles after tile_done.
- **Partial tiles:** K=3, M=6, N=5 → four commands in order:
  - a0 b0 c0 rows4
  - a3 b0 c4 rows2
  - a0 b3 c6 rows4
  - a3 b3 c10 rows2
- **Zero dimension:** M=0 → no `cmd_valid`; `done` at cycle 1; `busy` high for exactly 1 cycle.
- **Backpressure:** `cmd_ready` held low for 5 cycles → `cmd_valid` and payload stable for 5 cycles; `perf_stall`=5 when `TPU_SCHED_PERF_EN` is defined.
- **Spurious inputs:** `in_valid` with K=9 while busy, and `tile_done` while in ISSUE → both ignored; command fields still use the original K.
- **Mid-job reset:** `rst_n` low during WAIT of tile 2 → all outputs 0; a new job after reset starts at mt=0, nt=0.
